// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the D-format memory-stage engine.
//   - state_t          : transaction FSM states
//   - DWORD_ALIGN_BITS : low address bits that must be zero for a doubleword
//   - BYTE_MASK        : mask selecting the low byte of a 64-bit word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int          DWORD_ALIGN_BITS = 3;
  localparam logic [63:0] BYTE_MASK        = 64'hFF;

endpackage

// File: rtl/dmem_ea_calc.sv
// dmem_ea_calc
//   Combinational effective-address adder with doubleword alignment check.
//   Ports:
//     base_addr      in  ADDR_W  Rn value
//     dAddr9Extended in  ADDR_W  sign-extended 9-bit offset
//     op_is_byte     in  1       byte access (never misaligned)
//     ea             out ADDR_W  base_addr + offset, wraps modulo 2^ADDR_W
//     misaligned     out 1       doubleword access with ea[2:0] != 0
module dmem_ea_calc
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] dAddr9Extended,
  input  logic              op_is_byte,
  output logic [ADDR_W-1:0] ea,
  output logic              misaligned
);

  // Plain modular add: carry out is discarded, wrap-around is legal.
  assign ea         = base_addr + dAddr9Extended;
  assign misaligned = !op_is_byte && (ea[DWORD_ALIGN_BITS-1:0] != '0);

endmodule

// File: rtl/dtype_mem_access.sv
// dtype_mem_access
//   Memory-stage engine for LDUR/STUR/LDURB/STURB. Accepts an op in IDLE,
//   forms the effective address, runs a req/ack handshake with data memory
//   (with timeout), stalls the pipeline meanwhile, and reports exactly one
//   completion pulse (ld_valid, st_done or access_err) in RESP.
//   Ports:
//     clk, reset (async, active low)
//     op_valid/op_is_store/op_is_byte/base_addr/dAddr9Extended/store_data : op in
//     mem_req/mem_we/mem_addr/mem_wdata/mem_bytesel : request to memory
//     mem_ack/mem_rdata                             : memory completion
//     stall                                         : hold upstream pipeline
//     ld_valid/load_data, st_done, access_err       : completion to writeback
module dtype_mem_access
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_is_store,
  input  logic              op_is_byte,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] dAddr9Extended,
  input  logic [ADDR_W-1:0] store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              mem_bytesel,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [ADDR_W-1:0] load_data,
  output logic              st_done,
  output logic              access_err
);

  // Counter must be able to hold TIMEOUT_CYCLES (one past terminal count).
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_ea;
  logic [ADDR_W-1:0]   r_wdata;
  logic                r_is_store;
  logic                r_is_byte;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_load_data;

  logic [ADDR_W-1:0]   w_ea;
  logic                w_misaligned;
  logic                w_accept;
  logic                w_capture;
  logic                w_timeout;
  logic                w_req;
  logic                w_stall;

  dmem_ea_calc #(
    .ADDR_W(ADDR_W)
  ) u_ea_calc (
    .base_addr      (base_addr),
    .dAddr9Extended (dAddr9Extended),
    .op_is_byte     (op_is_byte),
    .ea             (w_ea),
    .misaligned     (w_misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_valid) begin
          w_accept     = 1'b1;
          w_stall      = 1'b1;
          // A misaligned doubleword never reaches memory.
          w_state_next = w_misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        w_req        = 1'b1;
        w_stall      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        // Ack is checked first so an ack on the terminal count still succeeds.
        if (mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end else if (r_cnt == CNT_TERM) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Transaction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ea        <= '0;
      r_wdata     <= '0;
      r_is_store  <= 1'b0;
      r_is_byte   <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= '0;
    end else begin
      if (w_accept) begin
        r_ea       <= w_ea;
        r_wdata    <= op_is_byte ? (store_data & ADDR_W'(BYTE_MASK)) : store_data;
        r_is_store <= op_is_store;
        r_is_byte  <= op_is_byte;
        r_err      <= w_misaligned;
        r_cnt      <= '0;
      end else if (r_state == REQ || r_state == WAIT) begin
        // Counts cycles since the request was first raised (REQ is cycle 0).
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      // Stores leave load_data untouched; it only changes on a load completion.
      if (w_capture && !r_is_store) begin
        r_load_data <= r_is_byte ? (mem_rdata & ADDR_W'(BYTE_MASK)) : mem_rdata;
      end
    end
  end

  assign mem_req     = w_req;
  assign mem_we      = w_req & r_is_store;
  assign mem_bytesel = w_req & r_is_byte;
  assign mem_addr    = r_ea;
  assign mem_wdata   = r_wdata;
  assign stall       = w_stall;
  assign load_data   = r_load_data;

  assign ld_valid    = (r_state == RESP) && !r_err && !r_is_store;
  assign st_done     = (r_state == RESP) && !r_err &&  r_is_store;
  assign access_err  = (r_state == RESP) &&  r_err;

endmodule

// File: tb/tb_dtype_mem_access.sv
// tb_dtype_mem_access
//   Directed stimulus with a scoreboard: each issued op pushes its expected
//   request fields and completion into a queue; a negedge monitor checks every
//   request cycle and pops/compares on every completion pulse.
module tb_dtype_mem_access;

  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_ERR = 2;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_is_store;
  logic        op_is_byte;
  logic [63:0] base_addr;
  logic [63:0] dAddr9Extended;
  logic [63:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_bytesel;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        ld_valid;
  logic [63:0] load_data;
  logic        st_done;
  logic        access_err;

  dtype_mem_access #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_is_store    (op_is_store),
    .op_is_byte     (op_is_byte),
    .base_addr      (base_addr),
    .dAddr9Extended (dAddr9Extended),
    .store_data     (store_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_bytesel    (mem_bytesel),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .ld_valid       (ld_valid),
    .load_data      (load_data),
    .st_done        (st_done),
    .access_err     (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] addr;
    logic        we;
    logic        bs;
    logic [63:0] wdata;
    logic [63:0] data;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_resp = 0;
  int   stall_cnt = 0;
  int   req_cnt = 0;
  logic [63:0] last_load = 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      stall_cnt = 0;
      req_cnt   = 0;
      last_load = 64'h0;
    end else begin
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_req: got mem_req=1 expected no request");
        end else begin
          check({sb[0].tag, "_addr"}, mem_addr, sb[0].addr);
          check({sb[0].tag, "_we"}, {63'b0, mem_we}, {63'b0, sb[0].we});
          check({sb[0].tag, "_bytesel"}, {63'b0, mem_bytesel}, {63'b0, sb[0].bs});
          if (sb[0].we) check({sb[0].tag, "_wdata"}, mem_wdata, sb[0].wdata);
        end
      end
      if (ld_valid || st_done || access_err) begin
        int   act_kind;
        exp_t e;
        act_kind = ({ld_valid, st_done, access_err} == 3'b100) ? K_LD  :
                   ({ld_valid, st_done, access_err} == 3'b010) ? K_ST  :
                   ({ld_valid, st_done, access_err} == 3'b001) ? K_ERR : 3;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got pulses ld=%0b st=%0b err=%0b expected none",
                   ld_valid, st_done, access_err);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_kind"}, 64'(act_kind), 64'(e.kind));
          check({e.tag, "_stall_cycles"}, 64'(stall_cnt), 64'(e.stalls));
          check({e.tag, "_req_cycles"}, 64'(req_cnt), 64'(e.reqs));
          check({e.tag, "_stall_in_resp"}, {63'b0, stall}, 64'h0);
          if (e.kind == K_LD) begin
            check({e.tag, "_load_data"}, load_data, e.data);
            last_load = e.data;
          end else begin
            check({e.tag, "_load_hold"}, load_data, last_load);
          end
          $display("txn %s: kind=%0d stalls=%0d reqs=%0d load_data=0x%0h",
                   e.tag, act_kind, stall_cnt, req_cnt, load_data);
        end
        n_resp++;
        stall_cnt = 0;
        req_cnt   = 0;
      end
    end
  end

  // Issue one op and act as memory: ack on the ack_n-th WAIT cycle (0 = never).
  task automatic run_op(input string tag, input logic st, input logic by,
                        input logic [63:0] base, input logic [63:0] off,
                        input logic [63:0] sdata, input int ack_n,
                        input logic [63:0] rdata, input int kind,
                        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                        input logic [63:0] exp_data, input int stalls, input int reqs);
    exp_t e;
    int   start;
    int   ack_at;
    bit   done;
    e.tag = tag; e.kind = kind; e.addr = exp_addr; e.we = st; e.bs = by;
    e.wdata = exp_wdata; e.data = exp_data; e.stalls = stalls; e.reqs = reqs;
    sb.push_back(e);
    start = n_resp;
    op_valid = 1'b1; op_is_store = st; op_is_byte = by;
    base_addr = base; dAddr9Extended = off; store_data = sdata;
    @(posedge clk); #1;
    op_valid = 1'b0;
    ack_at = (ack_n > 0) ? ack_n + 1 : -1;  // cycle 1 after acceptance is REQ
    done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : 64'hA5A5_5A5A_A5A5_5A5A;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (n_resp != start) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_resp: got no completion within 60 cycles expected one pulse", tag);
      sb.delete();
    end
  endtask

  initial begin
    int start;
    exp_t e;
    reset = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_is_byte = 1'b0;
    base_addr = '0; dAddr9Extended = '0; store_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #3;
    check("rst_mem_req", {63'b0, mem_req}, 64'h0);
    check("rst_stall", {63'b0, stall}, 64'h0);
    check("rst_pulses", {61'b0, ld_valid, st_done, access_err}, 64'h0);
    check("rst_mem_we_bs", {62'b0, mem_we, mem_bytesel}, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_load_data", load_data, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    //      tag          st    by    base                   offset                 sdata                  ack rdata                  kind   exp_addr               exp_wdata              exp_data              stl req
    run_op("ldur_basic", 1'b0, 1'b0, 64'h1000,              64'h10,                64'h0,                 2,  64'hDEADBEEF_CAFEF00D, K_LD,  64'h1010,              64'h0,                 64'hDEADBEEF_CAFEF00D, 4, 3);
    run_op("sturb_neg",  1'b1, 1'b1, 64'h2000,              64'hFFFF_FFFF_FFFF_FFFF, 64'h1234,            1,  64'h0,                 K_ST,  64'h1FFF,              64'h34,                64'h0,                 3, 2);
    run_op("ldur_wrap",  1'b0, 1'b0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,               1,  64'h0123_4567_89AB_CDEF, K_LD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,               64'h0123_4567_89AB_CDEF, 3, 2);
    run_op("ldurb_zext", 1'b0, 1'b1, 64'h3001,              64'h2,                 64'h0,                 3,  64'hFFFF_FFFF_FFFF_FF80, K_LD, 64'h3003,              64'h0,                 64'h80,                5, 4);
    run_op("ldur_misal", 1'b0, 1'b0, 64'h1003,              64'h0,                 64'h0,                 0,  64'h0,                 K_ERR, 64'h0,                 64'h0,                 64'h0,                 1, 0);
    run_op("stur_misal", 1'b1, 1'b0, 64'h100,               64'hFFFF_FFFF_FFFF_FFFC, 64'h77,              0,  64'h0,                 K_ERR, 64'h0,                 64'h0,                 64'h0,                 1, 0);
    run_op("stur_tmo",   1'b1, 1'b0, 64'h4000,              64'h8,                 64'hCAFE_0000_1111_2222, 0, 64'h0,                K_ERR, 64'h4008,              64'hCAFE_0000_1111_2222, 64'h0,               17, 16);
    run_op("stur_term",  1'b1, 1'b0, 64'h4010,              64'hFFFF_FFFF_FFFF_FFF0, 64'h5555_6666_7777_8888, 15, 64'h0,              K_ST,  64'h4000,              64'h5555_6666_7777_8888, 64'h0,               17, 16);

    // Stray ack while idle must produce nothing (monitor flags any pulse).
    mem_ack = 1'b1; mem_rdata = 64'h9999_9999_9999_9999;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a load's WAIT phase.
    e.tag = "ldur_rst"; e.kind = K_LD; e.addr = 64'h6000; e.we = 1'b0; e.bs = 1'b0;
    e.wdata = 64'h0; e.data = 64'h0; e.stalls = 0; e.reqs = 0;
    sb.push_back(e);
    start = n_resp;
    op_valid = 1'b1; op_is_store = 1'b0; op_is_byte = 1'b0;
    base_addr = 64'h6000; dAddr9Extended = 64'h0; store_data = 64'h0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("pre_rst_req", {63'b0, mem_req}, 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_mem_req", {63'b0, mem_req}, 64'h0);
    check("midrst_stall", {63'b0, stall}, 64'h0);
    check("midrst_load_data", load_data, 64'h0);
    check("midrst_mem_addr", mem_addr, 64'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_pulse", 64'(n_resp), 64'(start));

    run_op("ldur_after", 1'b0, 1'b0, 64'h500, 64'hF8, 64'h0, 1, 64'h1122_3344_5566_7788,
           K_LD, 64'h5F8, 64'h0, 64'h1122_3344_5566_7788, 3, 2);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
